// File: rtl/wb_arbiter_pkg.sv
// Shared configuration for the two-master Wishbone arbiter.
//   WB_ADDR_W / WB_DATA_W / WB_SEL_BITS : default bus geometry
//   owner_t : bus-owner encoding. One-hot per master, so it is also the
//             o_grant value.
package wb_arbiter_pkg;

  localparam int WB_ADDR_W   = 24;
  localparam int WB_DATA_W   = 16;
  localparam int WB_SEL_BITS = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Wishbone classic/pipelined bus bundle.
//   master modport : drives cyc/stb/we/adr/o_dat/sel, receives i_dat/ack/err
//   slave  modport : the opposite direction
// Handshake: cyc frames a bus tenure. A beat transfers on every clock edge
// where stb is high and ack or err is high. i_dat is only meaningful
// together with ack. Several stb beats may share one cyc tenure.
interface wb_arbiter_if #(
  parameter int ADDR_W = wb_arbiter_pkg::WB_ADDR_W,
  parameter int DATA_W = wb_arbiter_pkg::WB_DATA_W,
  parameter int SEL_W  = wb_arbiter_pkg::WB_SEL_BITS
);

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] o_dat;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] i_dat;
  logic              ack;
  logic              err;

  modport master (output cyc, stb, we, adr, o_dat, sel,
                  input  i_dat, ack, err);
  modport slave  (input  cyc, stb, we, adr, o_dat, sel,
                  output i_dat, ack, err);

endinterface

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts cycles of an unanswered strobe and forces a
// one-cycle error when the count expires.
//   i_clk, i_rst : clock, async active-high reset
//   active       : a granted master is strobing this cycle
//   resp         : a response (ack, err or a forced err) is seen this cycle
//   err_to       : registered one-cycle forced error
//   o_timeout    : registered pulse, coincident with err_to
// With TIMEOUT == 0 the watchdog is removed and both outputs stay low.
module wb_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic active,
  input  logic resp,
  output logic err_to,
  output logic o_timeout
);

  if (TIMEOUT > 0) begin : g_wd
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt       <= '0;
        err_to    <= 1'b0;
        o_timeout <= 1'b0;
      end else begin
        err_to    <= 1'b0;
        o_timeout <= 1'b0;
        // The forced err itself counts as a response, so the count restarts
        // from zero after every firing.
        if (!active || resp) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt       <= '0;
          err_to    <= 1'b1;
          o_timeout <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end else begin : g_off
    logic unused_wd;
    assign unused_wd = ^{i_clk, i_rst, active, resp};
    assign err_to    = 1'b0;
    assign o_timeout = 1'b0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin tie break and a
// bus watchdog.
//   i_clk, i_rst : clock, async active-high reset
//   m0_wb, m1_wb : master-side buses (arbiter acts as their slave)
//   s_wb         : slave-side bus (arbiter acts as its master)
//   o_grant      : one-hot current owner, bit n = master n
//   o_timeout    : one-cycle pulse when the watchdog forces an err
// A granted master keeps the bus until it drops cyc. Every tenure is
// followed by one idle cycle before the next grant.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_W  = WB_ADDR_W,
  parameter int DATA_W  = WB_DATA_W,
  parameter int SEL_W   = WB_SEL_BITS,
  parameter int TIMEOUT = 256
) (
  input  logic          i_clk,
  input  logic          i_rst,
  wb_arbiter_if.slave   m0_wb,
  wb_arbiter_if.slave   m1_wb,
  wb_arbiter_if.master  s_wb,
  output logic [1:0]    o_grant,
  output logic          o_timeout
);

  owner_t owner;
  logic   last;     // index of the master granted most recently
  logic   err_to;

  logic              own_cyc;
  logic              own_stb;
  logic              own_we;
  logic [ADDR_W-1:0] own_adr;
  logic [DATA_W-1:0] own_dat;
  logic [SEL_W-1:0]  own_sel;

  // Grant FSM. last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner <= OWN_NONE;
      last  <= 1'b1;
    end else begin
      case (owner)
        OWN_NONE: begin
          if (m0_wb.cyc && (!m1_wb.cyc || last)) begin
            owner <= OWN_M0;
            last  <= 1'b0;
          end else if (m1_wb.cyc) begin
            owner <= OWN_M1;
            last  <= 1'b1;
          end
        end
        OWN_M0:  if (!m0_wb.cyc) owner <= OWN_NONE;
        OWN_M1:  if (!m1_wb.cyc) owner <= OWN_NONE;
        default: owner <= OWN_NONE;
      endcase
    end
  end

  assign o_grant = owner;

  // Request path: the owner's signals, or all-zero when the bus is idle.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    case (owner)
      OWN_M0: begin
        own_cyc = m0_wb.cyc;
        own_stb = m0_wb.stb;
        own_we  = m0_wb.we;
        own_adr = m0_wb.adr;
        own_dat = m0_wb.o_dat;
        own_sel = m0_wb.sel;
      end
      OWN_M1: begin
        own_cyc = m1_wb.cyc;
        own_stb = m1_wb.stb;
        own_we  = m1_wb.we;
        own_adr = m1_wb.adr;
        own_dat = m1_wb.o_dat;
        own_sel = m1_wb.sel;
      end
      default: ;
    endcase
  end

  // The strobe is withheld from the slave while the forced err is returned,
  // so the slave does not see the abandoned beat a second time.
  assign s_wb.cyc   = own_cyc;
  assign s_wb.stb   = own_stb & ~err_to;
  assign s_wb.we    = own_we;
  assign s_wb.adr   = own_adr;
  assign s_wb.o_dat = own_dat;
  assign s_wb.sel   = own_sel;

  // Response path: only the owner sees the slave; the other master reads 0.
  assign m0_wb.i_dat = (owner == OWN_M0) ? s_wb.i_dat : '0;
  assign m0_wb.ack   = (owner == OWN_M0) & s_wb.ack;
  assign m0_wb.err   = (owner == OWN_M0) & (s_wb.err | err_to);
  assign m1_wb.i_dat = (owner == OWN_M1) ? s_wb.i_dat : '0;
  assign m1_wb.ack   = (owner == OWN_M1) & s_wb.ack;
  assign m1_wb.err   = (owner == OWN_M1) & (s_wb.err | err_to);

  wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .active    (own_cyc & own_stb),
    .resp      (s_wb.ack | s_wb.err | err_to),
    .err_to    (err_to),
    .o_timeout (o_timeout)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [1:0] o_grant;
  logic       o_timeout;

  always #5 i_clk = ~i_clk;

  wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) m0_wb ();
  wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) m1_wb ();
  wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) s_wb ();

  wb_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .SEL_W  (SW),
    .TIMEOUT(TO)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .m0_wb    (m0_wb),
    .m1_wb    (m1_wb),
    .s_wb     (s_wb),
    .o_grant  (o_grant),
    .o_timeout(o_timeout)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  // {master index, read data} expected on each master ack
  logic [16:0] exp_q[$];
  // expected owner on each idle -> granted transition
  logic [1:0]  exp_grant_q[$];
  logic [1:0]  prev_grant = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after the rising edge; outputs are sampled
  // 2 units later, well away from either clock edge.
  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic clear_inputs();
    m0_wb.cyc = 1'b0; m0_wb.stb = 1'b0; m0_wb.we = 1'b0;
    m0_wb.adr = '0;   m0_wb.o_dat = '0; m0_wb.sel = '0;
    m1_wb.cyc = 1'b0; m1_wb.stb = 1'b0; m1_wb.we = 1'b0;
    m1_wb.adr = '0;   m1_wb.o_dat = '0; m1_wb.sel = '0;
    s_wb.ack = 1'b0;  s_wb.err = 1'b0;  s_wb.i_dat = '0;
  endtask

  task automatic drive_m0(input logic cyc, input logic [AW-1:0] adr);
    m0_wb.cyc = cyc; m0_wb.stb = cyc; m0_wb.we = 1'b0;
    m0_wb.adr = adr; m0_wb.o_dat = 16'h1111; m0_wb.sel = 2'b11;
  endtask

  task automatic drive_m1(input logic cyc, input logic [AW-1:0] adr);
    m1_wb.cyc = cyc; m1_wb.stb = cyc; m1_wb.we = 1'b1;
    m1_wb.adr = adr; m1_wb.o_dat = 16'h2222; m1_wb.sel = 2'b01;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic sb_ack(input logic who, input logic [DW-1:0] dat);
    logic [16:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_ack: got ack to m%0d data %h, expected no ack", who, dat);
    end else begin
      e = exp_q.pop_front();
      if (e !== {who, dat}) begin
        n_errors++;
        $display("FAIL sb_ack: got m%0d data %h, expected m%0d data %h", who, dat, e[16], e[15:0]);
      end
    end
  endtask

  task automatic sb_grant(input logic [1:0] g);
    logic [1:0] e;
    n_checks++;
    if (exp_grant_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_grant: got grant %b, expected no grant", g);
    end else begin
      e = exp_grant_q.pop_front();
      if (e !== g) begin
        n_errors++;
        $display("FAIL sb_grant: got grant %b, expected %b", g, e);
      end
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (m0_wb.ack) sb_ack(1'b0, m0_wb.i_dat);
      if (m1_wb.ack) sb_ack(1'b1, m1_wb.i_dat);
      if (o_grant != 2'b00 && prev_grant == 2'b00) sb_grant(o_grant);
    end
    prev_grant = o_grant;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        m0_cyc;
    logic        m1_cyc;
    logic        s_ack;
    logic        s_err;
    logic [15:0] s_dat;
    logic [1:0]  grant;
    logic        s_cyc;
    logic        s_we;
    logic [23:0] s_adr;
    logic        m0_ack;
    logic        m0_err;
    logic [15:0] m0_dat;
    logic        m1_ack;
    logic        m1_err;
    logic [15:0] m1_dat;
  } vec_t;

  vec_t vecs[4];

  // Two masters request together from idle, slave answers without wait
  // states. Stops once both are served and the bus is idle again; a
  // handover to a waiting master must happen 2 cycles after the owner
  // drops cyc. With gaps set, master 0 strobes only every other cycle.
  task automatic run_burst(input int n0, input int n1, input bit gaps, input string tag);
    int         left0 = n0;
    int         left1 = n1;
    int         cyc_i = 0;
    int         drop_c = -1;
    logic       prev0, prev1;
    logic [1:0] pg = 2'b00;
    bit         done = 1'b0;
    logic [15:0] d;
    m0_wb.we = 1'b0; m0_wb.adr = 24'h001000; m0_wb.sel = 2'b11; m0_wb.o_dat = 16'h0;
    m1_wb.we = 1'b1; m1_wb.adr = 24'h003000; m1_wb.sel = 2'b10;
    m1_wb.o_dat = 16'($urandom_range(0, 65535));
    while (!done && cyc_i < 100) begin
      prev0 = m0_wb.cyc;
      prev1 = m1_wb.cyc;
      m0_wb.cyc = (left0 > 0);
      m0_wb.stb = (left0 > 0) && !(gaps && (cyc_i % 2 == 1));
      m1_wb.cyc = (left1 > 0);
      m1_wb.stb = (left1 > 0);
      if (prev0 && !m0_wb.cyc && left1 > 0) drop_c = cyc_i;
      if (prev1 && !m1_wb.cyc && left0 > 0) drop_c = cyc_i;
      if (o_grant != 2'b00 && pg == 2'b00 && drop_c >= 0) begin
        check({tag, "_handover_cycles"}, 32'(cyc_i - drop_c), 32'd2);
        drop_c = -1;
      end
      s_wb.ack = 1'b0;
      s_wb.i_dat = '0;
      d = 16'($urandom_range(0, 65535));
      if (o_grant == 2'b01 && m0_wb.stb) begin
        s_wb.ack = 1'b1; s_wb.i_dat = d; exp_q.push_back({1'b0, d}); left0--;
      end else if (o_grant == 2'b10 && m1_wb.stb) begin
        s_wb.ack = 1'b1; s_wb.i_dat = d; exp_q.push_back({1'b1, d}); left1--;
      end
      if (left0 == 0 && left1 == 0 && o_grant == 2'b00) done = 1'b1;
      pg = o_grant;
      if (!done) begin
        step();
        cyc_i++;
      end
    end
    s_wb.ack = 1'b0;
    s_wb.i_dat = '0;
    check({tag, "_done_in_budget"}, 32'(done), 32'd1);
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic fire;
    clear_inputs();

    // Reset state: outputs stay zero under reset even with busy inputs.
    i_rst = 1'b1;
    drive_m0(1'b1, 24'h002000);
    drive_m1(1'b1, 24'h00F000);
    s_wb.ack = 1'b1; s_wb.err = 1'b1; s_wb.i_dat = 16'hFFFF;
    step(); step(); #2;
    check("rst_s_cyc", 32'(s_wb.cyc), 32'd0);
    check("rst_s_stb", 32'(s_wb.stb), 32'd0);
    check("rst_s_adr", 32'(s_wb.adr), 32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_m0_ack_err", 32'({m0_wb.ack, m0_wb.err}), 32'd0);
    check("rst_m1_ack_err", 32'({m1_wb.ack, m1_wb.err}), 32'd0);
    check("rst_m0_dat", 32'(m0_wb.i_dat), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    clear_inputs();
    i_rst = 1'b0;

    // Table: fresh reset, one arbitration edge, then a slave response.
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 2'b01, 1'b1, 1'b0, 24'h002000,
                1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 2'b10, 1'b1, 1'b1, 24'h00F000,
                1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h55AA, 2'b01, 1'b1, 1'b0, 24'h002000,
                1'b1, 1'b1, 16'h55AA, 1'b0, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 2'b00, 1'b0, 1'b0, 24'h000000,
                1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      step();
      i_rst = 1'b1;
      clear_inputs();
      #1;
      i_rst = 1'b0;
      drive_m0(vecs[i].m0_cyc, 24'h002000);
      drive_m1(vecs[i].m1_cyc, 24'h00F000);
      if (vecs[i].grant != 2'b00) exp_grant_q.push_back(vecs[i].grant);
      step();
      s_wb.ack = vecs[i].s_ack; s_wb.err = vecs[i].s_err; s_wb.i_dat = vecs[i].s_dat;
      if (vecs[i].m0_ack) exp_q.push_back({1'b0, vecs[i].m0_dat});
      if (vecs[i].m1_ack) exp_q.push_back({1'b1, vecs[i].m1_dat});
      #2;
      check($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(vecs[i].grant));
      check($sformatf("vec%0d_s_cyc", i), 32'(s_wb.cyc), 32'(vecs[i].s_cyc));
      check($sformatf("vec%0d_s_we", i), 32'(s_wb.we), 32'(vecs[i].s_we));
      check($sformatf("vec%0d_s_adr", i), 32'(s_wb.adr), 32'(vecs[i].s_adr));
      check($sformatf("vec%0d_m0_resp", i), 32'({m0_wb.ack, m0_wb.err, m0_wb.i_dat}),
            32'({vecs[i].m0_ack, vecs[i].m0_err, vecs[i].m0_dat}));
      check($sformatf("vec%0d_m1_resp", i), 32'({m1_wb.ack, m1_wb.err, m1_wb.i_dat}),
            32'({vecs[i].m1_ack, vecs[i].m1_err, vecs[i].m1_dat}));
    end
    step();
    clear_inputs();
    step(); step();

    // Single read by master 0, slave answers on the third granted cycle.
    exp_grant_q.push_back(2'b01);
    drive_m0(1'b1, 24'h002000);
    #2;
    check("rd_latency_s_cyc", 32'(s_wb.cyc), 32'd0);
    step(); #2;
    check("rd_s_cyc", 32'(s_wb.cyc), 32'd1);
    check("rd_grant", 32'(o_grant), 32'd1);
    check("rd_s_adr", 32'(s_wb.adr), 32'h002000);
    step(); #2;
    check("rd_wait_m0_ack", 32'(m0_wb.ack), 32'd0);
    step();
    s_wb.ack = 1'b1; s_wb.i_dat = 16'hBEEF;
    exp_q.push_back({1'b0, 16'hBEEF});
    #2;
    check("rd_m0_ack", 32'(m0_wb.ack), 32'd1);
    check("rd_m0_dat", 32'(m0_wb.i_dat), 32'hBEEF);
    check("rd_m1_quiet", 32'({m1_wb.ack, m1_wb.i_dat}), 32'd0);
    step();
    clear_inputs();
    step(); step();

    // Round-robin sequences; expected owners derived from who went last.
    exp_grant_q.push_back(2'b10);
    run_burst(0, 1, 1'b0, "m1_alone");
    exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
    run_burst(3, 3, 1'b0, "tie_a");
    exp_grant_q.push_back(2'b01); exp_grant_q.push_back(2'b10);
    run_burst(4, 2, 1'b1, "hold_beats");
    exp_grant_q.push_back(2'b01);
    run_burst(1, 0, 1'b0, "m0_alone");
    exp_grant_q.push_back(2'b10); exp_grant_q.push_back(2'b01);
    run_burst(3, 3, 1'b0, "tie_b");
    clear_inputs();
    step();

    // Watchdog: master 1 writes to a silent address and keeps strobing.
    // Forced err every 9th cycle; at cycle 18 the slave acks at the same time.
    exp_grant_q.push_back(2'b10);
    drive_m1(1'b1, 24'hFFFFF0);
    for (int i = 1; i <= 27; i++) begin
      step();
      s_wb.ack   = (i == 18);
      s_wb.i_dat = (i == 18) ? 16'h1357 : 16'h0000;
      if (i == 18) exp_q.push_back({1'b1, 16'h1357});
      fire = (i == 9) || (i == 18) || (i == 27);
      #2;
      check($sformatf("wd_m1_err_c%0d", i), 32'(m1_wb.err), 32'(fire));
      check($sformatf("wd_pulse_c%0d", i), 32'(o_timeout), 32'(fire));
      check($sformatf("wd_s_stb_c%0d", i), 32'(s_wb.stb), 32'(!fire));
      if (fire) begin
        check($sformatf("wd_m0_err_c%0d", i), 32'(m0_wb.err), 32'd0);
        check($sformatf("wd_s_cyc_c%0d", i), 32'(s_wb.cyc), 32'd1);
      end
      if (i == 18) check("wd_ack_with_err", 32'(m1_wb.ack), 32'd1);
    end
    step();
    clear_inputs();
    step(); step();

    // Asynchronous reset between edges in the middle of a response.
    exp_grant_q.push_back(2'b01);
    drive_m0(1'b1, 24'h002000);
    step(); step();
    s_wb.ack = 1'b1; s_wb.i_dat = 16'hCAFE;
    #1;
    check("arst_pre_m0_ack", 32'({s_wb.cyc, m0_wb.ack}), 32'b11);
    i_rst = 1'b1;
    #1;
    check("arst_s_cyc", 32'(s_wb.cyc), 32'd0);
    check("arst_grant", 32'(o_grant), 32'd0);
    check("arst_acks", 32'({m0_wb.ack, m1_wb.ack}), 32'd0);
    check("arst_m0_dat", 32'(m0_wb.i_dat), 32'd0);
    clear_inputs();
    #3;
    i_rst = 1'b0;
    exp_grant_q.push_back(2'b01);
    drive_m0(1'b1, 24'h002000);
    drive_m1(1'b1, 24'h00F000);
    step(); #2;
    check("arst_tie_grant", 32'(o_grant), 32'd1);
    step();
    clear_inputs();
    step(); step(); step();

    // ---------------- final report ----------------
    check("sb_ack_queue_empty", 32'(exp_q.size()), 32'd0);
    check("sb_grant_queue_empty", 32'(exp_grant_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of test, expected end before 100000 time units");
    $fatal(1, "simulation time limit");
  end

endmodule
